// File: rtl/mc_pkg.sv
// mc_pkg: shared state codes, opcodes, funct codes and ALU-op encodings for the multicycle control unit
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BEQ    = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/mc_aludec.sv
// mc_aludec: maps the FSM's aluop class and the R-type funct field to a 3-bit ALU control code
module mc_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  logic [2:0] rtype;
  // R-type operation from funct; unknown functs fall back to add
  always_comb begin
    rtype = 3'b010;
    case (funct)
      F_ADD:   rtype = 3'b010;
      F_SUB:   rtype = 3'b110;
      F_AND:   rtype = 3'b000;
      F_OR:    rtype = 3'b001;
      F_SLT:   rtype = 3'b111;
      default: rtype = 3'b010;
    endcase
  end
  // aluop 01 forces subtract for branch compare, 10 defers to funct, anything else adds
  always_comb alucontrol = aluop == ALUOP_SUB ? 3'b110 : aluop == ALUOP_FUNCT ? rtype : 3'b010;
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore main FSM of the multicycle MIPS core driving all datapath selects and enables
module mc_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic [STATE_W-1:0] state
);
  state_t st, nxt;
  logic pcwrite, branch;
  logic [1:0] aluop;
  // state register; reset wins over any in-flight instruction
  always_ff @(posedge clk) st <= reset ? FETCH : nxt;
  // next state and per-state control outputs; everything not named in a state stays 0
  always_comb begin
    nxt      = FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    case (st)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
        nxt     = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
              op == OP_R    ? EXEC   :
              op == OP_BEQ  ? BEQ    :
              op == OP_ADDI ? ADDIEX :
              op == OP_J    ? JUMP   : FETCH;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = op == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        nxt     = ALUWB;
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQ: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  assign pcen  = pcwrite | (branch & zero);
  assign state = STATE_W'(st);
  mc_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: randomized scoreboard bench comparing every cycle against an instruction-level model
module tb_mc_controller;
  typedef struct packed {
    logic [3:0] st;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
  } rec_t;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  rec_t exp_q[$];
  int checks = 0, errors = 0;
  bit mon_en = 1'b0;
  mc_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
  );
  always #5 clk = ~clk;
  function automatic logic [2:0] alu_ref(input logic [5:0] f);
    case (f)
      6'd32: return 3'd2;
      6'd34: return 3'd6;
      6'd36: return 3'd0;
      6'd37: return 3'd1;
      6'd42: return 3'd7;
      default: return 3'd2;
    endcase
  endfunction
  function automatic rec_t expect_out(input int s, input logic [5:0] f, input logic z);
    rec_t r = '0;
    r.st = 4'(s);
    r.alucontrol = 3'd2;
    case (s)
      0:  begin r.irwrite = 1; r.pcen = 1; r.alusrcb = 2'b01; end
      1:  r.alusrcb = 2'b11;
      2:  begin r.alusrca = 1; r.alusrcb = 2'b10; end
      3:  r.iord = 1;
      4:  begin r.memtoreg = 1; r.regwrite = 1; end
      5:  begin r.iord = 1; r.memwrite = 1; end
      6:  begin r.alusrca = 1; r.alucontrol = alu_ref(f); end
      7:  begin r.regdst = 1; r.regwrite = 1; end
      8:  begin r.alusrca = 1; r.alucontrol = 3'd6; r.pcsrc = 2'b01; r.pcen = z; end
      9:  begin r.alusrca = 1; r.alusrcb = 2'b10; end
      10: r.regwrite = 1;
      11: begin r.pcsrc = 2'b10; r.pcen = 1; end
      default: ;
    endcase
    return r;
  endfunction
  function automatic void path_of(input logic [5:0] o, output int p[$]);
    case (o)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b000100: p = '{0, 1, 8};
      6'b001000: p = '{0, 1, 9, 10};
      6'b000010: p = '{0, 1, 11};
      default:   p = '{0, 1};
    endcase
  endfunction
  task automatic step(input int s);
    exp_q.push_back(expect_out(s, funct, zero));
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    int p[$];
    op = o;
    funct = f;
    zero = z;
    path_of(o, p);
    foreach (p[i]) step(p[i]);
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      rec_t got, want;
      got = '{state, pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
              alusrcb, pcsrc, alucontrol};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL underflow: dut state %0d with no expectation queued", state);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL ctrl t=%0t: got st=%0d bits=%h, expected st=%0d bits=%h",
                   $time, got.st, got, want.st, want);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  localparam logic [5:0] LEGAL_OPS [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  localparam logic [5:0] FUNCTS [5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(0);
    reset = 1'b0;
    run_instr(6'b100011, 6'd0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b0);
    run_instr(6'b000000, 6'b101010, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1);
    run_instr(6'b000100, 6'd0, 1'b0);
    run_instr(6'b001000, 6'd0, 1'b0);
    run_instr(6'b000010, 6'd0, 1'b0);
    op = 6'b100011;
    step(0);
    step(1);
    step(2);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    run_instr(6'b111111, 6'd0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      logic [5:0] o, f;
      o = $urandom_range(0, 3) == 0 ? 6'($urandom) : LEGAL_OPS[$urandom_range(0, 5)];
      f = $urandom_range(0, 2) == 0 ? 6'($urandom) : FUNCTS[$urandom_range(0, 4)];
      run_instr(o, f, 1'($urandom));
    end
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations unconsumed, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
